// File: rtl/alu_fib_seq.sv
// Purpose : drives ADD requests into a registered 6-bit ALU and feeds each sum
//           back as the next operand, producing a Fibonacci-style sequence.
// Latency : first term 3 cycles after an accepted start, then one every 2 cycles.
// Backpressure: none; start is accepted only in IDLE and is otherwise dropped.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, seed0, seed1 run request and the two seeds (sampled in IDLE)
//   alu_s/alu_a/alu_b   ALU request (opcode is always add)
//   alu_f/alu_result    ALU response, valid the cycle after the request
//   busy, done          run in progress / one-cycle end-of-run pulse
//   out_valid/out_data  emitted term strobe and held term value
//   count, ovf, err     terms emitted, carry stop, protocol-error stop
module alu_fib_seq #(
  parameter int MAX_TERMS = 12,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       seed0,
  input  logic [5:0]       seed1,
  output logic [2:0]       alu_s,
  output logic [5:0]       alu_a,
  output logic [5:0]       alu_b,
  input  logic [1:0]       alu_f,
  input  logic [5:0]       alu_result,
  output logic             busy,
  output logic             out_valid,
  output logic [5:0]       out_data,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] F_CARRY  = 2'b01;
  localparam logic [1:0] F_BORROW = 2'b10;

  // Comparing against MAX_TERMS-1 before the increment avoids a wider compare.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_TERMS - 1);

  state_t state;

  assign alu_s = 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      out_data  <= '0;
      count     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            alu_a <= seed0;
            alu_b <= seed1;
            count <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        // Operands are held stable; the ALU captures them at the end of this cycle.
        ISSUE: state <= WAIT;
        WAIT: begin
          if (alu_f == F_CARRY) begin
            ovf   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (alu_f == F_BORROW) begin
            // An add can never legitimately borrow: treat as a protocol error.
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // Normal and zero results both continue the sequence.
            out_data  <= alu_result;
            out_valid <= 1'b1;
            count     <= count + 1'b1;
            alu_a     <= alu_b;
            alu_b     <= alu_result;
            if (count == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_fib_seq.sv
module tb_alu_fib_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start12, start5, stub_en;
  logic [5:0] seed0, seed1;

  // Instance with the default term limit
  logic [2:0] s12;
  logic [5:0] a12, b12, r12, od12;
  logic [1:0] f12;
  logic       busy12, ov12, done12, ovf12, err12;
  logic [3:0] cnt12;

  // Instance with a term limit of 5
  logic [2:0] s5;
  logic [5:0] a5, b5, r5, od5;
  logic [1:0] f5;
  logic       busy5, ov5, done5, ovf5, err5;
  logic [3:0] cnt5;

  alu_fib_seq #(.MAX_TERMS(12), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start12), .seed0(seed0), .seed1(seed1),
    .alu_s(s12), .alu_a(a12), .alu_b(b12), .alu_f(f12), .alu_result(r12),
    .busy(busy12), .out_valid(ov12), .out_data(od12), .count(cnt12),
    .done(done12), .ovf(ovf12), .err(err12)
  );

  alu_fib_seq #(.MAX_TERMS(5), .CNT_W(4)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .seed0(seed0), .seed1(seed1),
    .alu_s(s5), .alu_a(a5), .alu_b(b5), .alu_f(f5), .alu_result(r5),
    .busy(busy5), .out_valid(ov5), .out_data(od5), .count(cnt5),
    .done(done5), .ovf(ovf5), .err(err5)
  );

  // Registered 6-bit adder models. Carry beats zero; the stub forces the
  // borrow flag on every request after the first emitted term.
  logic [6:0] sum12, sum5;
  logic       stub_seen;
  assign sum12 = {1'b0, a12} + {1'b0, b12};
  assign sum5  = {1'b0, a5} + {1'b0, b5};

  always @(posedge clk) begin
    r12 <= sum12[5:0];
    if (stub_en && (stub_seen || ov12)) f12 <= 2'b10;
    else if (sum12[6])                  f12 <= 2'b01;
    else if (sum12[5:0] == 6'd0)        f12 <= 2'b11;
    else                                f12 <= 2'b00;
    if (!stub_en)  stub_seen <= 1'b0;
    else if (ov12) stub_seen <= 1'b1;
  end

  always @(posedge clk) begin
    r5 <= sum5[5:0];
    if (sum5[6])                 f5 <= 2'b01;
    else if (sum5[5:0] == 6'd0)  f5 <= 2'b11;
    else                         f5 <= 2'b00;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];
  int         cyc_q[$];
  int         done_cnt, done_cyc;
  logic       busy_gap, busy_after;

  // Pulse start for one cycle; returns 1 time unit after the accepting edge.
  task automatic pulse_start(input bit sel, input logic [5:0] s0, input logic [5:0] s1);
    @(posedge clk); #1;
    seed0 = s0; seed1 = s1;
    if (sel) start5 = 1'b1; else start12 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0; start12 = 1'b0;
  endtask

  // Records emitted terms (and their cycle after start) until one cycle past
  // done or maxc cycles. Optionally pulses rst or start at a given cycle.
  task automatic collect(input bit sel, input int maxc, input int rst_c, input int poke_c);
    obs_q.delete(); cyc_q.delete();
    done_cnt = 0; done_cyc = -1; busy_gap = 1'b0; busy_after = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (c == rst_c) rst = 1'b1;
      else if (c == rst_c + 1) rst = 1'b0;
      if (c == poke_c) begin
        if (sel) start5 = 1'b1; else start12 = 1'b1;
      end else if (c == poke_c + 1) begin
        start5 = 1'b0; start12 = 1'b0;
      end
      if (sel ? ov5 : ov12) begin
        obs_q.push_back(sel ? od5 : od12);
        cyc_q.push_back(c);
      end
      if (sel ? done5 : done12) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cyc < 0 && !(sel ? busy5 : busy12)) busy_gap = 1'b1;
      if (done_cyc > 0 && c == done_cyc + 1) begin
        busy_after = sel ? busy5 : busy12;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({busy12, ov12, done12, ovf12, err12} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy12, ov12, done12, ovf12, err12}); end
    n_checks++; if ({a12, b12} !== 12'd0) begin n_fail++; $display("FAIL reset_operands: got a=%0d b=%0d want 0 0", a12, b12); end
    n_checks++; if (od12 !== 6'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", od12); end
    n_checks++; if (cnt12 !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt12); end
    n_checks++; if ({s12, s5} !== 6'b0) begin n_fail++; $display("FAIL alu_opcode: got %b %b want 000 000", s12, s5); end
    n_checks++; if ({busy5, ov5, done5, ovf5, err5, cnt5} !== 9'b0) begin n_fail++; $display("FAIL reset_dut5: got %b want 0", {busy5, ov5, done5, ovf5, err5, cnt5}); end
    rst = 1'b0;
  endtask

  task automatic test_fib_carry();
    logic [5:0] e, o;
    int i;
    exp_q = '{6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34, 6'd55};
    pulse_start(1'b0, 6'd1, 6'd1);
    collect(1'b0, 40, -1, -1);
    n_checks++; if (obs_q.size() !== 8) begin n_fail++; $display("FAIL fib_term_count: got %0d want 8", obs_q.size()); end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL fib_term_missing: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        n_checks++; if (o !== e) begin n_fail++; $display("FAIL fib_term: got %0d want %0d", o, e); end
        n_checks++; if (cyc_q.pop_front() !== 3 + 2 * i) begin n_fail++; $display("FAIL fib_term_cycle: term %0d not at cycle %0d", i, 3 + 2 * i); end
      end
      i++;
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL fib_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc !== 19) begin n_fail++; $display("FAIL fib_done_cycle: got %0d want 19", done_cyc); end
    n_checks++; if ({ovf12, err12} !== 2'b10) begin n_fail++; $display("FAIL fib_ovf_err: got %b want 10", {ovf12, err12}); end
    n_checks++; if (cnt12 !== 4'd8) begin n_fail++; $display("FAIL fib_count: got %0d want 8", cnt12); end
    n_checks++; if (od12 !== 6'd55) begin n_fail++; $display("FAIL fib_held_data: got %0d want 55", od12); end
    n_checks++; if ({busy_gap, busy_after} !== 2'b00) begin n_fail++; $display("FAIL fib_busy: got gap=%b after=%b want 0 0", busy_gap, busy_after); end
  endtask

  task automatic test_zero_limit();
    logic [5:0] e, o;
    for (int i = 0; i < 12; i++) exp_q.push_back(6'd0);
    pulse_start(1'b0, 6'd0, 6'd0);
    collect(1'b0, 60, -1, -1);
    n_checks++; if (obs_q.size() !== 12) begin n_fail++; $display("FAIL zero_term_count: got %0d want 12", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL zero_term_missing: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        n_checks++; if (o !== e) begin n_fail++; $display("FAIL zero_term: got %0d want %0d", o, e); end
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if ({ovf12, err12} !== 2'b00) begin n_fail++; $display("FAIL zero_ovf_err: got %b want 00", {ovf12, err12}); end
    n_checks++; if (cnt12 !== 4'd12) begin n_fail++; $display("FAIL zero_count: got %0d want 12", cnt12); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b want 0", busy_after); end
  endtask

  task automatic test_first_carry();
    pulse_start(1'b0, 6'd63, 6'd1);
    collect(1'b0, 20, -1, -1);
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL carry0_terms: got %0d want 0", obs_q.size()); end
    n_checks++; if (done_cyc !== 3) begin n_fail++; $display("FAIL carry0_done_cycle: got %0d want 3", done_cyc); end
    n_checks++; if ({ovf12, err12} !== 2'b10) begin n_fail++; $display("FAIL carry0_ovf_err: got %b want 10", {ovf12, err12}); end
    n_checks++; if (cnt12 !== 4'd0) begin n_fail++; $display("FAIL carry0_count: got %0d want 0", cnt12); end
  endtask

  task automatic test_limit5_ignore_start();
    logic [5:0] e, o;
    int extra;
    exp_q = '{6'd1, 6'd2, 6'd3, 6'd5, 6'd8};
    pulse_start(1'b1, 6'd0, 6'd1);
    collect(1'b1, 40, -1, 4);
    n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL lim5_term_count: got %0d want 5", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL lim5_term_missing: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        n_checks++; if (o !== e) begin n_fail++; $display("FAIL lim5_term: got %0d want %0d", o, e); end
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL lim5_done_pulses: got %0d want 1", done_cnt); end
    n_checks++; if ({ovf5, err5} !== 2'b00) begin n_fail++; $display("FAIL lim5_ovf_err: got %b want 00", {ovf5, err5}); end
    n_checks++; if (cnt5 !== 4'd5) begin n_fail++; $display("FAIL lim5_count: got %0d want 5", cnt5); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov5 || busy5) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL lim5_queued_start: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_rst_midrun();
    logic [5:0] e, o;
    pulse_start(1'b0, 6'd1, 6'd1);
    collect(1'b0, 7, 6, -1);
    n_checks++; if (obs_q.size() !== 2) begin n_fail++; $display("FAIL rst_terms_before: got %0d want 2", obs_q.size()); end
    n_checks++; if ({busy12, ov12, done12, ovf12, err12} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_flags: got %b want 00000", {busy12, ov12, done12, ovf12, err12}); end
    n_checks++; if ({a12, b12, od12, cnt12} !== 22'd0) begin n_fail++; $display("FAIL rst_mid_regs: got a=%0d b=%0d d=%0d c=%0d want 0", a12, b12, od12, cnt12); end
    exp_q = '{6'd5, 6'd8, 6'd13, 6'd21, 6'd34, 6'd55};
    pulse_start(1'b0, 6'd2, 6'd3);
    collect(1'b0, 40, -1, -1);
    n_checks++; if (cyc_q.size() == 0 || cyc_q[0] !== 3) begin n_fail++; $display("FAIL rst_restart_first_cycle: first term not at cycle 3 (terms=%0d)", cyc_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL rst_restart_missing: got none want %0d", e); end
      else begin
        o = obs_q.pop_front();
        n_checks++; if (o !== e) begin n_fail++; $display("FAIL rst_restart_term: got %0d want %0d", o, e); end
      end
    end
    n_checks++; if (cnt12 !== 4'd6) begin n_fail++; $display("FAIL rst_restart_count: got %0d want 6", cnt12); end
    n_checks++; if (ovf12 !== 1'b1) begin n_fail++; $display("FAIL rst_restart_ovf: got %b want 1", ovf12); end
  endtask

  task automatic test_stub_err();
    stub_en = 1'b1;
    exp_q = '{6'd3};
    pulse_start(1'b0, 6'd1, 6'd2);
    collect(1'b0, 20, -1, -1);
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL err_term_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++; if (obs_q.pop_front() !== exp_q.pop_front()) begin n_fail++; $display("FAIL err_term: got %0d want 3", od12); end
    end
    n_checks++; if ({ovf12, err12} !== 2'b01) begin n_fail++; $display("FAIL err_ovf_err: got %b want 01", {ovf12, err12}); end
    n_checks++; if (cnt12 !== 4'd1) begin n_fail++; $display("FAIL err_count: got %0d want 1", cnt12); end
    n_checks++; if (done_cyc !== 5) begin n_fail++; $display("FAIL err_done_cycle: got %0d want 5", done_cyc); end
    stub_en = 1'b0;
    exp_q.delete();
    pulse_start(1'b0, 6'd1, 6'd1);
    @(negedge clk);
    n_checks++; if ({busy12, err12, ovf12} !== 3'b100) begin n_fail++; $display("FAIL err_cleared_on_start: got %b want 100", {busy12, err12, ovf12}); end
    collect(1'b0, 40, -1, -1);
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL err_next_run_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    rst = 1'b1; start12 = 1'b0; start5 = 1'b0; stub_en = 1'b0;
    seed0 = 6'd0; seed1 = 6'd0;
    test_reset();
    test_fib_carry();
    test_zero_limit();
    test_first_carry();
    test_limit5_ignore_start();
    test_rst_midrun();
    test_stub_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
